// File: rtl/bp_upd_sched.sv
`default_nettype none
//==============================================================================
// bp_upd_sched : branch-predictor update scheduler (BTB/PHT write queue +
//                mispredict redirect). Optional stats counters: BP_UPD_STATS_EN
// Revision     : 1.0
//==============================================================================
module bp_upd_sched #(
  parameter int PC_WIDTH   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_res_vld,
  output logic                o_res_rdy,
  input  logic [PC_WIDTH-1:0] i_res_pc,
  input  logic                i_res_is_br,
  input  logic                i_res_taken,
  input  logic [PC_WIDTH-1:0] i_res_target,
  input  logic                i_res_pred_hit,
  input  logic                i_res_pred_taken,
  input  logic [PC_WIDTH-1:0] i_res_pred_target,
  input  logic                i_hold,
  output logic                o_upd_btb_vld,
  output logic [PC_WIDTH-1:0] o_upd_btb_pc,
  output logic [PC_WIDTH-1:0] o_upd_btb_br_addr,
  output logic                o_upd_pht_vld,
  output logic [PC_WIDTH-1:0] o_upd_pht_pc,
  output logic                o_upd_pht_taken,
  output logic                o_redirect_vld,
  output logic [PC_WIDTH-1:0] o_redirect_pc,
  output logic [CNT_WIDTH-1:0] o_br_cnt,
  output logic [CNT_WIDTH-1:0] o_mispred_cnt
);

  localparam int c_AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_RUN   = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_AW:0]       r_wptr;
  logic [c_AW:0]       r_rptr;
  logic [PC_WIDTH-1:0] r_pc_q  [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] r_tgt_q [FIFO_DEPTH];
  logic                r_br_q  [FIFO_DEPTH];
  logic                r_tk_q  [FIFO_DEPTH];
  logic                r_nb_q  [FIFO_DEPTH];
  logic                r_redir_vld;
  logic [PC_WIDTH-1:0] r_redir_pc;

  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_taken_eff;
  logic                w_tgt_mis;
  logic                w_need_btb;
  logic                w_mispred;
  logic [c_AW:0]       w_wptr_nxt;
  logic [c_AW:0]       w_rptr_nxt;
  logic [c_AW-1:0]     w_head;
  logic [c_AW-1:0]     w_tail;

  assign w_full = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                  (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign o_res_rdy = ~w_full;
  assign w_push    = i_res_vld & ~w_full;
  // No same-cycle bypass: an entry becomes poppable only once the state leaves EMPTY.
  assign w_pop     = (r_state != S_EMPTY) & ~i_hold;

  assign w_taken_eff = ~i_res_is_br | i_res_taken;
  assign w_tgt_mis   = (i_res_pred_target != i_res_target);
  assign w_need_btb  = w_taken_eff & (~i_res_pred_hit | w_tgt_mis);
  assign w_mispred   = (w_taken_eff != i_res_pred_taken) | (w_taken_eff & w_tgt_mis);

  assign w_wptr_nxt = r_wptr + {{c_AW{1'b0}}, w_push};
  assign w_rptr_nxt = r_rptr + {{c_AW{1'b0}}, w_pop};
  assign w_head     = r_rptr[c_AW-1:0];
  assign w_tail     = r_wptr[c_AW-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_EMPTY;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
      if (w_wptr_nxt == w_rptr_nxt) begin
        r_state <= S_EMPTY;
      end else if (i_hold) begin
        r_state <= S_HELD;
      end else begin
        r_state <= S_RUN;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_pc_q[w_tail]  <= i_res_pc;
      r_tgt_q[w_tail] <= i_res_target;
      r_br_q[w_tail]  <= i_res_is_br;
      r_tk_q[w_tail]  <= w_taken_eff;
      r_nb_q[w_tail]  <= w_need_btb;
    end
  end

  assign o_upd_pht_vld     = w_pop & r_br_q[w_head];
  assign o_upd_pht_pc      = r_pc_q[w_head];
  assign o_upd_pht_taken   = r_tk_q[w_head];
  assign o_upd_btb_vld     = w_pop & r_nb_q[w_head];
  assign o_upd_btb_pc      = r_pc_q[w_head];
  assign o_upd_btb_br_addr = r_tgt_q[w_head];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_redir_vld <= 1'b0;
      r_redir_pc  <= '0;
    end else begin
      r_redir_vld <= w_push & w_mispred;
      if (w_push & w_mispred) begin
        r_redir_pc <= w_taken_eff ? i_res_target : (i_res_pc + PC_WIDTH'(4));
      end
    end
  end

  assign o_redirect_vld = r_redir_vld;
  assign o_redirect_pc  = r_redir_pc;

`ifdef BP_UPD_STATS_EN
  logic [CNT_WIDTH-1:0] r_br_cnt;
  logic [CNT_WIDTH-1:0] r_mispred_cnt;

  // Both counters saturate rather than wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_push && i_res_is_br && (r_br_cnt != '1)) begin
        r_br_cnt <= r_br_cnt + CNT_WIDTH'(1);
      end
      if (w_push && w_mispred && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign o_br_cnt      = r_br_cnt;
  assign o_mispred_cnt = r_mispred_cnt;
`else
  assign o_br_cnt      = '0;
  assign o_mispred_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_upd_sched.sv
`default_nettype none
//==============================================================================
// tb_bp_upd_sched : directed self-checking bench for bp_upd_sched
// Revision        : 1.0
//==============================================================================
module tb_bp_upd_sched;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_res_vld = 1'b0;
  logic        o_res_rdy;
  logic [31:0] i_res_pc = '0;
  logic        i_res_is_br = 1'b0;
  logic        i_res_taken = 1'b0;
  logic [31:0] i_res_target = '0;
  logic        i_res_pred_hit = 1'b0;
  logic        i_res_pred_taken = 1'b0;
  logic [31:0] i_res_pred_target = '0;
  logic        i_hold = 1'b0;
  logic        o_upd_btb_vld;
  logic [31:0] o_upd_btb_pc;
  logic [31:0] o_upd_btb_br_addr;
  logic        o_upd_pht_vld;
  logic [31:0] o_upd_pht_pc;
  logic        o_upd_pht_taken;
  logic        o_redirect_vld;
  logic [31:0] o_redirect_pc;
  logic [15:0] o_br_cnt;
  logic [15:0] o_mispred_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  bp_upd_sched #(.PC_WIDTH(32), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_res_vld(i_res_vld), .o_res_rdy(o_res_rdy),
    .i_res_pc(i_res_pc), .i_res_is_br(i_res_is_br), .i_res_taken(i_res_taken),
    .i_res_target(i_res_target), .i_res_pred_hit(i_res_pred_hit),
    .i_res_pred_taken(i_res_pred_taken), .i_res_pred_target(i_res_pred_target),
    .i_hold(i_hold),
    .o_upd_btb_vld(o_upd_btb_vld), .o_upd_btb_pc(o_upd_btb_pc),
    .o_upd_btb_br_addr(o_upd_btb_br_addr),
    .o_upd_pht_vld(o_upd_pht_vld), .o_upd_pht_pc(o_upd_pht_pc),
    .o_upd_pht_taken(o_upd_pht_taken),
    .o_redirect_vld(o_redirect_vld), .o_redirect_pc(o_redirect_pc),
    .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic br, input logic tk,
                       input logic [31:0] tgt, input logic hit, input logic ptk,
                       input logic [31:0] ptgt);
    i_res_vld         = 1'b1;
    i_res_pc          = pc;
    i_res_is_br       = br;
    i_res_taken       = tk;
    i_res_target      = tgt;
    i_res_pred_hit    = hit;
    i_res_pred_taken  = ptk;
    i_res_pred_target = ptgt;
  endtask

  task automatic send(input logic [31:0] pc, input logic br, input logic tk,
                      input logic [31:0] tgt, input logic hit, input logic ptk,
                      input logic [31:0] ptgt);
    drive(pc, br, tk, tgt, hit, ptk, ptgt);
    tick();
    i_res_vld = 1'b0;
  endtask

  initial begin
    // Reset
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    chk_eq("rst_rdy",       64'(o_res_rdy), 64'd1);
    chk_eq("rst_pht_vld",   64'(o_upd_pht_vld), 64'd0);
    chk_eq("rst_btb_vld",   64'(o_upd_btb_vld), 64'd0);
    chk_eq("rst_redir_vld", 64'(o_redirect_vld), 64'd0);
    chk_eq("rst_redir_pc",  64'(o_redirect_pc), 64'd0);
    chk_eq("rst_br_cnt",    64'(o_br_cnt), 64'd0);

    // Taken branch, BTB miss, predicted not-taken
    send(32'h100, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104);
    chk_eq("t1_redir_vld", 64'(o_redirect_vld), 64'd1);
    chk_eq("t1_redir_pc",  64'(o_redirect_pc), 64'h80);
    chk_eq("t1_pht_vld",   64'(o_upd_pht_vld), 64'd1);
    chk_eq("t1_pht_pc",    64'(o_upd_pht_pc), 64'h100);
    chk_eq("t1_pht_tk",    64'(o_upd_pht_taken), 64'd1);
    chk_eq("t1_btb_vld",   64'(o_upd_btb_vld), 64'd1);
    chk_eq("t1_btb_pc",    64'(o_upd_btb_pc), 64'h100);
    chk_eq("t1_btb_addr",  64'(o_upd_btb_br_addr), 64'h80);
    tick();
    chk_eq("t1_redir_pulse", 64'(o_redirect_vld), 64'd0);
    chk_eq("t1_drained",     64'(o_upd_pht_vld), 64'd0);

    // Correctly predicted not-taken branch
    send(32'h200, 1'b1, 1'b0, 32'h280, 1'b1, 1'b0, 32'h204);
    chk_eq("t2_redir_vld", 64'(o_redirect_vld), 64'd0);
    chk_eq("t2_pht_vld",   64'(o_upd_pht_vld), 64'd1);
    chk_eq("t2_pht_tk",    64'(o_upd_pht_taken), 64'd0);
    chk_eq("t2_btb_vld",   64'(o_upd_btb_vld), 64'd0);
    tick();

    // Jump with wrong predicted target
    send(32'h300, 1'b0, 1'b0, 32'h400, 1'b1, 1'b1, 32'h500);
    chk_eq("t3_redir_vld", 64'(o_redirect_vld), 64'd1);
    chk_eq("t3_redir_pc",  64'(o_redirect_pc), 64'h400);
    chk_eq("t3_btb_vld",   64'(o_upd_btb_vld), 64'd1);
    chk_eq("t3_btb_addr",  64'(o_upd_btb_br_addr), 64'h400);
    chk_eq("t3_pht_vld",   64'(o_upd_pht_vld), 64'd0);
    tick();

    // Predicted taken, actually not taken: redirect to pc+4, including wrap
    send(32'h600, 1'b1, 1'b0, 32'h700, 1'b1, 1'b1, 32'h700);
    chk_eq("t4_redir_pc", 64'(o_redirect_pc), 64'h604);
    chk_eq("t4_btb_vld",  64'(o_upd_btb_vld), 64'd0);
    tick();
    send(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h10, 1'b1, 1'b1, 32'h10);
    chk_eq("t5_redir_vld", 64'(o_redirect_vld), 64'd1);
    chk_eq("t5_redir_wrap", 64'(o_redirect_pc), 64'h0);
    tick();

    // Hold: fill the queue, then release and drain in order
    i_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(32'h1000 + 32'(16 * k), 1'b1, 1'(k & 1), 32'h9000, 1'b1, 1'(k & 1), 32'h9000);
      chk_eq("hold_no_pht", 64'(o_upd_pht_vld), 64'd0);
      chk_eq("hold_no_btb", 64'(o_upd_btb_vld), 64'd0);
    end
    chk_eq("hold_full_rdy", 64'(o_res_rdy), 64'd0);
    i_hold = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk_eq("drain_vld", 64'(o_upd_pht_vld), 64'd1);
      chk_eq("drain_pc",  64'(o_upd_pht_pc), 64'h1000 + 64'(16 * k));
      chk_eq("drain_tk",  64'(o_upd_pht_taken), 64'(k & 1));
      chk_eq("drain_rdy", 64'(o_res_rdy), (k == 0) ? 64'd0 : 64'd1);
      tick();
    end
    chk_eq("drain_empty", 64'(o_upd_pht_vld), 64'd0);

    // Streaming with two resident entries
    i_hold = 1'b1;
    send(32'h2000, 1'b1, 1'b1, 32'h3000, 1'b1, 1'b1, 32'h3000);
    send(32'h2004, 1'b1, 1'b1, 32'h3000, 1'b1, 1'b1, 32'h3000);
    i_hold = 1'b0;
    for (int j = 0; j < 20; j++) begin
      drive(32'h2000 + 32'(4 * (j + 2)), 1'b1, 1'b1, 32'h3000, 1'b1, 1'b1, 32'h3000);
      #1;
      chk_eq("stream_pc",  64'(o_upd_pht_pc), 64'h2000 + 64'(4 * j));
      chk_eq("stream_vld", 64'(o_upd_pht_vld), 64'd1);
      chk_eq("stream_rdy", 64'(o_res_rdy), 64'd1);
      tick();
    end
    i_res_vld = 1'b0;
    chk_eq("stream_tail0", 64'(o_upd_pht_pc), 64'h2050);
    tick();
    chk_eq("stream_tail1", 64'(o_upd_pht_pc), 64'h2054);
    tick();
    chk_eq("stream_empty", 64'(o_upd_pht_vld), 64'd0);

    // Reset mid-operation discards queued entries
    i_hold = 1'b1;
    for (int k = 0; k < 3; k++) send(32'h5000 + 32'(4 * k), 1'b1, 1'b1, 32'h5100, 1'b0, 1'b0, 32'h0);
    i_hold = 1'b0;
    i_rst  = 1'b1;
    tick();
    i_rst = 1'b0;
    chk_eq("mrst_pht_vld",   64'(o_upd_pht_vld), 64'd0);
    chk_eq("mrst_btb_vld",   64'(o_upd_btb_vld), 64'd0);
    chk_eq("mrst_redir_pc",  64'(o_redirect_pc), 64'd0);
    chk_eq("mrst_rdy",       64'(o_res_rdy), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_eq("mrst_no_stale", 64'(o_upd_pht_vld), 64'd0);
    end

    // Statistics
    for (int k = 0; k < 10; k++) begin
      send(32'h7000 + 32'(4 * k), 1'b1, 1'b1, 32'h7800, 1'b1, (k >= 3), 32'h7800);
    end
`ifdef BP_UPD_STATS_EN
    chk_eq("stat_br",      64'(o_br_cnt), 64'd10);
    chk_eq("stat_mispred", 64'(o_mispred_cnt), 64'd3);
    drive(32'h8000, 1'b1, 1'b0, 32'h8800, 1'b1, 1'b0, 32'h8800);
    for (int k = 0; k < 70000; k++) @(posedge i_clk);
    #1;
    i_res_vld = 1'b0;
    chk_eq("stat_br_sat",  64'(o_br_cnt), 64'hFFFF);
    chk_eq("stat_mis_hold", 64'(o_mispred_cnt), 64'd3);
`else
    chk_eq("stat_br_off",      64'(o_br_cnt), 64'd0);
    chk_eq("stat_mispred_off", 64'(o_mispred_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bp_upd_sched.md
# bp_upd_sched

Branch-predictor update scheduler sitting between the execute-stage branch resolution logic and the gshare predictor's BTB/PHT update ports. It accepts one resolved control-flow instruction per cycle through a valid/ready handshake and detects mispredictions, raising a registered front-end redirect. Each resolved branch or jump is buffered in a small FIFO, then issued to the predictor as at most one BTB write plus one PHT write per cycle. A hold input freezes issue, for example while the predictor is being re-initialised.

## Interface
- PC_WIDTH, 32, program counter and target width
- FIFO_DEPTH, 4, update queue entries; power of two, ≥2
- CNT_WIDTH, 16, statistics counter width

Ports:
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_res_vld  in  1  resolved control-flow instruction presented
- o_res_rdy  out  1  scheduler can accept; equals ~full
- i_res_pc  in  PC_WIDTH  PC of the instruction
- i_res_is_br  in  1  1 = conditional branch, 0 = unconditional jump
- i_res_taken  in  1  actual outcome (ignored for jumps, treated as 1)
- i_res_target  in  PC_WIDTH  actual taken target
- i_res_pred_hit  in  1  BTB hit at fetch
- i_res_pred_taken  in  1  predictor taken at fetch
- i_res_pred_target  in  PC_WIDTH  predicted next PC at fetch
- i_hold  in  1  suppress issue; queue retained
- o_upd_btb_vld / o_upd_btb_pc / o_upd_btb_br_addr  out  1/PC_WIDTH/PC_WIDTH  BTB write port
- o_upd_pht_vld / o_upd_pht_pc / o_upd_pht_taken  out  1/PC_WIDTH/1  PHT update port
- o_redirect_vld  out  1  mispredict redirect, one-cycle pulse
- o_redirect_pc  out  PC_WIDTH  correct next PC
- o_br_cnt, o_mispred_cnt  out  CNT_WIDTH  statistics (see Configuration)

## Operation
- Accept = i_res_vld & o_res_rdy. On accept, push {pc, is_br, taken_eff, target, need_btb} into the FIFO.
  - taken_eff = is_br ? taken : 1.
- need_btb = taken_eff & (~pred_hit | pred_target != target).
- Mispredict (evaluated on accept):
  - taken_eff != pred_taken, or
  - taken_eff & pred_target != target.
- Issue (pop) when FIFO non-empty and ~i_hold. Outputs are combinational from the FIFO head:
  - o_upd_pht_vld = pop & is_br; o_upd_pht_pc = head pc; o_upd_pht_taken = head taken_eff.
  - o_upd_btb_vld = pop & need_btb; o_upd_btb_pc = head pc; o_upd_btb_br_addr = head target.
  - A head entry that needs neither update is still popped, with no write asserted.
- FSM, registered state:
  - EMPTY: count=0.
  - RUN: count>0 & ~i_hold.
  - HELD: count>0 & i_hold.
  - EMPTY→RUN/HELD on push. RUN↔HELD follows i_hold. RUN→EMPTY when the last entry pops with no push.
  - i_hold while EMPTY stays EMPTY; the next push goes directly to HELD.
- FIFO arithmetic: read/write pointers of log2(FIFO_DEPTH)+1 bits wrap naturally. Full when the MSBs differ and the remaining bits are equal.
- Simultaneous push and pop with 0<count<FIFO_DEPTH: count unchanged. Push and pop in the same cycle at full is not possible (rdy=0). At empty, no same-cycle bypass.
- Redirect: on a mispredicted accept, o_redirect_vld=1 next cycle.
  - o_redirect_pc = taken_eff ? target : pc+4 (modulo 2^PC_WIDTH).
  - Otherwise o_redirect_vld=0. Redirect is independent of i_hold and FIFO occupancy.

## Timing
- Reset values, taking effect the cycle after i_rst high:
  - Pointers 0, state EMPTY, o_res_rdy=1.
  - All o_upd_*_vld=0; o_redirect_vld=0, o_redirect_pc=0; counters 0.
  - Reset mid-operation discards queued entries.
- Accept at edge N: update visible on ports during cycle N+1 (if not held); predictor writes at edge N+1.
- Redirect: accept at edge N → o_redirect_vld high for cycle N+1 only.
- Throughput: one accept and one issue per cycle. Back-to-back branches sustain full rate with no bubbles.
- o_res_rdy falls in the cycle after the push that fills the FIFO.

## Configuration
- BP_UPD_STATS_EN defined:
  - o_br_cnt increments on every accept with is_br=1.
  - o_mispred_cnt increments on every mispredicted accept.
  - Both saturate at all-ones and clear on reset.
- Undefined: counters are not instantiated and both outputs are tied to 0.

## Test plan
- Branch pc=0x100, taken=1, target=0x80, pred_hit=0, pred_taken=0, pred_target=0x104 → next cycle: redirect 0x80; pht_vld with taken=1; btb_vld pc=0x100 br_addr=0x80.
- Branch pc=0x200, taken=0, pred_taken=0, pred_hit=1 → no redirect; pht_vld with taken=0; btb_vld=0.
- Jump pc=0x300, target=0x400, pred_hit=1, pred_taken=1, pred_target=0x500 → redirect 0x400; btb_vld br_addr=0x400; pht_vld=0.
- i_hold=1, push 4 entries (FIFO_DEPTH=4) → o_res_rdy=0, no update pulses; release hold → 4 consecutive issues in push order, rdy=1 after the first pop.
- Push and pop every cycle for 20 cycles with 2 entries resident → count stays 2, issue order preserved, rdy stays 1.
- Fill 3 entries, assert i_rst one cycle → next cycle EMPTY, all valids 0, no stale issue afterwards.
- With BP_UPD_STATS_EN: 10 branches, 3 mispredicted → o_br_cnt=10, o_mispred_cnt=3; 70000 branches → o_br_cnt saturates at 0xFFFF.
